// File: rtl/rf_param_ckpt.sv
// ---------------------------------------------------------------------------
// rf_param_ckpt
//
// Parametrised two-read / one-write register file with a single-level
// checkpoint. The checkpoint is a full shadow copy of the file. It can be
// saved or restored in one cycle, which lets the pipeline recover
// architectural state after a branch mispredict or an exception flush.
//
// Sits in decode: the two read ports feed ID/EX, and the write port is
// driven from writeback.
//
// Parameters
//   DATA_W    width of each register in bits
//   ADDR_W    width of the register select fields
//   NUM_REGS  number of implemented registers (must be <= 2**ADDR_W)
//   BYPASS    1 = a write in the current cycle is forwarded to the read ports
//   R0_ZERO   1 = register 0 always reads 0 and ignores writes
//
// Ports
//   clk           clock; all state updates on the rising edge
//   rst           synchronous active-high reset; overrides every other input
//   read1regsel   read port 1 select
//   read2regsel   read port 2 select
//   writeregsel   write select
//   writedata     write data
//   write         write enable
//   ckpt_save     copy the whole file, including this cycle's write, to the shadow
//   ckpt_restore  copy the shadow back into the file; this wins over a write
//   read1data     read port 1 data (combinational)
//   read2data     read port 2 data (combinational)
//   ckpt_valid    the shadow holds a saved checkpoint
//   err           sticky error flag, cleared only by rst
// ---------------------------------------------------------------------------
module rf_param_ckpt #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8,
    parameter int BYPASS   = 1,
    parameter int R0_ZERO  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read1regsel,
    input  logic [ADDR_W-1:0] read2regsel,
    input  logic [ADDR_W-1:0] writeregsel,
    input  logic [DATA_W-1:0] writedata,
    input  logic              write,
    input  logic              ckpt_save,
    input  logic              ckpt_restore,
    output logic [DATA_W-1:0] read1data,
    output logic [DATA_W-1:0] read2data,
    output logic              ckpt_valid,
    output logic              err
);

    // -----------------------------------------------------------------------
    // Elaboration guard: more registers than the select field can address
    // is a configuration error. It must stop the build here and must not
    // quietly leave registers that cannot be reached.
    // -----------------------------------------------------------------------
    if (NUM_REGS > (1 << ADDR_W)) begin : g_num_regs_too_large
        $error("rf_param_ckpt: NUM_REGS (%0d) exceeds 2**ADDR_W (%0d)",
               NUM_REGS, 1 << ADDR_W);
    end

    if (NUM_REGS < 1) begin : g_num_regs_too_small
        $error("rf_param_ckpt: NUM_REGS must be at least 1");
    end

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // A select addresses an implemented register. The comparison is one bit
    // wider than the select field, so NUM_REGS == 2**ADDR_W is still exact.
    function automatic logic in_range(input logic [ADDR_W-1:0] sel);
        return ({1'b0, sel} < (ADDR_W + 1)'(NUM_REGS));
    endfunction

    // Register 0 is hardwired to zero in this configuration.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] sel);
        return (R0_ZERO != 0) && (sel == '0);
    endfunction

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] regs   [NUM_REGS];
    logic [DATA_W-1:0] shadow [NUM_REGS];

    // -----------------------------------------------------------------------
    // Write qualification
    //   wr_fwd     a legal write this cycle that is not cancelled by a
    //              restore. Only this kind of write may be forwarded.
    //   wr_commit  wr_fwd minus writes to a hardwired-zero R0. These writes
    //              are dropped without raising an error.
    //   wr_bad     a write to an unimplemented index. It is dropped and
    //              raises err. An out-of-range select is flagged even when
    //              a restore cancels the write.
    // -----------------------------------------------------------------------
    logic wr_in_range;
    logic wr_fwd;
    logic wr_commit;
    logic wr_bad;

    assign wr_in_range = in_range(writeregsel);
    assign wr_fwd      = write && wr_in_range && !ckpt_restore;
    assign wr_commit   = wr_fwd && !is_zero_reg(writeregsel);
    assign wr_bad      = write && !wr_in_range;

    // -----------------------------------------------------------------------
    // reg_after: the contents of the file after this cycle's write, ignoring
    // any restore. The file loads it on a normal cycle. The shadow captures
    // it on a save, so a write in the same cycle is part of the checkpoint.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] reg_after [NUM_REGS];

    // NOTE: every variable driven here gets a default before any condition,
    // so synthesis sees pure combinational logic and infers no latch.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_after[i] = regs[i];
            if (wr_commit && (writeregsel == ADDR_W'(i))) begin
                reg_after[i] = writedata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Error sources, all folded into the sticky err flag:
    //   - a write to an unimplemented index
    //   - a restore when no checkpoint has been saved
    //   - a save and a restore in the same cycle (the save is dropped)
    // -----------------------------------------------------------------------
    logic restore_empty;
    logic save_conflict;
    logic err_event;

    assign restore_empty = ckpt_restore && !ckpt_valid;
    assign save_conflict = ckpt_restore && ckpt_save;
    assign err_event     = wr_bad || restore_empty || save_conflict;

    // A save takes effect only when no restore competes with it.
    logic save_take;
    assign save_take = ckpt_save && !ckpt_restore;

    // -----------------------------------------------------------------------
    // State update
    // -----------------------------------------------------------------------
    // NOTE: both arrays are cleared on reset. A restore after reset with no
    // save must produce a zero file, so the shadow needs a defined value and
    // cannot be mapped to a reset-less RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]   <= '0;
                shadow[i] <= '0;
            end
            ckpt_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments are used throughout. The shadow
            // then samples reg_after, and the file samples the shadow, both
            // as they were before this edge. A save and a restore therefore
            // never see each other's update.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ckpt_restore) begin
                    regs[i] <= shadow[i];
                end else begin
                    regs[i] <= reg_after[i];
                end

                if (save_take) begin
                    shadow[i] <= reg_after[i];
                end
            end

            // A restore leaves ckpt_valid unchanged, so the same
            // checkpoint can be restored repeatedly.
            if (save_take) begin
                ckpt_valid <= 1'b1;
            end

            if (err_event) begin
                err <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports
    // Both ports share one piece of logic, indexed by port number.
    // Priority: unimplemented index -> hardwired R0 -> same-cycle forward
    // -> stored value.
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_sel  [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_sel[0] = read1regsel;
    assign rd_sel[1] = read2regsel;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if (in_range(rd_sel[p]) && !is_zero_reg(rd_sel[p])) begin
                if ((BYPASS != 0) && wr_fwd && (writeregsel == rd_sel[p])) begin
                    rd_data[p] = writedata;
                end else begin
                    rd_data[p] = regs[rd_sel[p]];
                end
            end
        end
    end

    assign read1data = rd_data[0];
    assign read2data = rd_data[1];

endmodule

// File: tb/tb_rf_param_ckpt.sv
// ---------------------------------------------------------------------------
// tb_rf_param_ckpt
//
// Drives four configurations of rf_param_ckpt from the same inputs:
//   0 (CA): 8 regs, bypass on,  R0 writable   (defaults)
//   1 (CB): 8 regs, bypass off, R0 writable
//   2 (CC): 6 regs, bypass on,  R0 writable   (indices 6 and 7 unimplemented)
//   3 (CD): 8 regs, bypass on,  R0 hardwired to zero
// The directed scenarios compare against fixed values. The random scenario
// compares against a reference model that applies the register-file rules
// directly to plain arrays.
// ---------------------------------------------------------------------------
module tb_rf_param_ckpt;

    localparam int CA = 0;
    localparam int CB = 1;
    localparam int CC = 2;
    localparam int CD = 3;

    logic        clk;
    logic        rst;
    logic [2:0]  read1regsel;
    logic [2:0]  read2regsel;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic        write;
    logic        ckpt_save;
    logic        ckpt_restore;

    logic [15:0] rd1 [4];
    logic [15:0] rd2 [4];
    logic [3:0]  cv;
    logic [3:0]  er;

    int checks = 0;
    int errors = 0;

    rf_param_ckpt #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8), .BYPASS(1), .R0_ZERO(0)) dut_a (
        .clk(clk), .rst(rst), .read1regsel(read1regsel), .read2regsel(read2regsel),
        .writeregsel(writeregsel), .writedata(writedata), .write(write),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
        .read1data(rd1[0]), .read2data(rd2[0]), .ckpt_valid(cv[0]), .err(er[0]));

    rf_param_ckpt #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8), .BYPASS(0), .R0_ZERO(0)) dut_b (
        .clk(clk), .rst(rst), .read1regsel(read1regsel), .read2regsel(read2regsel),
        .writeregsel(writeregsel), .writedata(writedata), .write(write),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
        .read1data(rd1[1]), .read2data(rd2[1]), .ckpt_valid(cv[1]), .err(er[1]));

    rf_param_ckpt #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(6), .BYPASS(1), .R0_ZERO(0)) dut_c (
        .clk(clk), .rst(rst), .read1regsel(read1regsel), .read2regsel(read2regsel),
        .writeregsel(writeregsel), .writedata(writedata), .write(write),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
        .read1data(rd1[2]), .read2data(rd2[2]), .ckpt_valid(cv[2]), .err(er[2]));

    rf_param_ckpt #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8), .BYPASS(1), .R0_ZERO(1)) dut_d (
        .clk(clk), .rst(rst), .read1regsel(read1regsel), .read2regsel(read2regsel),
        .writeregsel(writeregsel), .writedata(writedata), .write(write),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
        .read1data(rd1[3]), .read2data(rd2[3]), .ckpt_valid(cv[3]), .err(er[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model: architectural contents, shadow, valid and err for
    // each configuration.
    // ---------------------------------------------------------------------
    int          nregs [4] = '{8, 8, 6, 8};
    bit          byp   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit          r0z   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] m_reg [4][8];
    logic [15:0] m_sh  [4][8];
    bit          m_cv  [4];
    bit          m_err [4];

    function automatic logic [15:0] exp_read(input int c, input logic [2:0] sel);
        if (int'(sel) >= nregs[c]) return 16'h0000;
        if (r0z[c] && sel == 3'd0) return 16'h0000;
        if (byp[c] && write && !ckpt_restore && writeregsel == sel) return writedata;
        return m_reg[c][sel];
    endfunction

    task automatic model_step();
        logic [15:0] nxt [8];
        for (int c = 0; c < 4; c++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    m_reg[c][i] = 16'h0000;
                    m_sh[c][i]  = 16'h0000;
                end
                m_cv[c]  = 1'b0;
                m_err[c] = 1'b0;
            end else begin
                nxt = m_reg[c];
                if (write && int'(writeregsel) < nregs[c] && !(r0z[c] && writeregsel == 3'd0))
                    nxt[writeregsel] = writedata;
                if (write && int'(writeregsel) >= nregs[c]) m_err[c] = 1'b1;
                if (ckpt_restore) begin
                    if (!m_cv[c] || ckpt_save) m_err[c] = 1'b1;
                    m_reg[c] = m_sh[c];
                end else begin
                    m_reg[c] = nxt;
                    if (ckpt_save) begin
                        m_sh[c] = nxt;
                        m_cv[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; write = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
        writeregsel = 3'd0; writedata = 16'h0000;
        read1regsel = 3'd0; read2regsel = 3'd0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 8; s++) begin
            read1regsel = 3'(s);
            read2regsel = 3'(7 - s);
            #1;
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (rd1[c] !== 16'h0000 || rd2[c] !== 16'h0000) begin
                    errors++;
                    $display("FAIL reset_read cfg%0d sel%0d got %h/%h exp 0000/0000", c, s, rd1[c], rd2[c]);
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (cv[c] !== 1'b0 || er[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags cfg%0d got valid=%b err=%b exp 0/0", c, cv[c], er[c]);
            end
        end
    endtask

    task automatic test_write_read();
        write = 1'b1; writeregsel = 3'd3; writedata = 16'hBEEF;
        step();
        write = 1'b0; read1regsel = 3'd3; read2regsel = 3'd4;
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rd1[c] !== 16'hBEEF) begin
                errors++;
                $display("FAIL wr_rd_r3 cfg%0d got %h exp BEEF", c, rd1[c]);
            end
            checks++;
            if (rd2[c] !== 16'h0000) begin
                errors++;
                $display("FAIL wr_rd_r4 cfg%0d got %h exp 0000", c, rd2[c]);
            end
        end
    endtask

    task automatic test_bypass();
        write = 1'b1; writeregsel = 3'd5; writedata = 16'h1234; read1regsel = 3'd5;
        #1;
        checks++;
        if (rd1[CA] !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_on got %h exp 1234", rd1[CA]);
        end
        checks++;
        if (rd1[CB] !== 16'h0000) begin
            errors++;
            $display("FAIL bypass_off_before got %h exp 0000", rd1[CB]);
        end
        step();
        write = 1'b0;
        #1;
        checks++;
        if (rd1[CB] !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_off_after got %h exp 1234", rd1[CB]);
        end
        // A restore cancels forwarding even though a legal write is present.
        ckpt_restore = 1'b0; write = 1'b1; writeregsel = 3'd5; writedata = 16'h7777;
        ckpt_restore = 1'b1;
        #1;
        checks++;
        if (rd1[CA] !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_restore got %h exp 1234", rd1[CA]);
        end
        idle();
    endtask

    task automatic test_ckpt_roundtrip();
        do_reset();
        write = 1'b1; writeregsel = 3'd1; writedata = 16'h0011; step();
        writeregsel = 3'd2; writedata = 16'h0022; step();
        writeregsel = 3'd2; writedata = 16'h00AA; ckpt_save = 1'b1; step();
        ckpt_save = 1'b0;
        checks++;
        if (cv[CA] !== 1'b1) begin
            errors++;
            $display("FAIL rt_valid got %b exp 1", cv[CA]);
        end
        writeregsel = 3'd1; writedata = 16'hFFFF; step();
        writeregsel = 3'd2; writedata = 16'hEEEE; step();
        writeregsel = 3'd1; writedata = 16'h5555; ckpt_restore = 1'b1; step();
        idle();
        read1regsel = 3'd1; read2regsel = 3'd2;
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rd1[c] !== 16'h0011 || rd2[c] !== 16'h00AA) begin
                errors++;
                $display("FAIL rt_restore cfg%0d got %h/%h exp 0011/00AA", c, rd1[c], rd2[c]);
            end
            checks++;
            if (er[c] !== 1'b0 || cv[c] !== 1'b1) begin
                errors++;
                $display("FAIL rt_flags cfg%0d got err=%b valid=%b exp 0/1", c, er[c], cv[c]);
            end
        end
    endtask

    task automatic test_bad_index();
        do_reset();
        write = 1'b1; writeregsel = 3'd7; writedata = 16'h5A5A; read1regsel = 3'd7;
        #1;
        checks++;
        if (rd1[CC] !== 16'h0000) begin
            errors++;
            $display("FAIL bad_idx_fwd got %h exp 0000", rd1[CC]);
        end
        checks++;
        if (rd1[CA] !== 16'h5A5A) begin
            errors++;
            $display("FAIL good_idx7_fwd got %h exp 5A5A", rd1[CA]);
        end
        step();
        write = 1'b0;
        #1;
        checks++;
        if (er[CC] !== 1'b1 || er[CA] !== 1'b0) begin
            errors++;
            $display("FAIL bad_idx_err got cfgC=%b cfgA=%b exp 1/0", er[CC], er[CA]);
        end
        checks++;
        if (rd1[CC] !== 16'h0000) begin
            errors++;
            $display("FAIL bad_idx_read got %h exp 0000", rd1[CC]);
        end
        for (int s = 0; s < 6; s++) begin
            read2regsel = 3'(s);
            #1;
            checks++;
            if (rd2[CC] !== 16'h0000) begin
                errors++;
                $display("FAIL bad_idx_nochange r%0d got %h exp 0000", s, rd2[CC]);
            end
        end
        step(); step();
        checks++;
        if (er[CC] !== 1'b1) begin
            errors++;
            $display("FAIL bad_idx_sticky got %b exp 1", er[CC]);
        end
    endtask

    task automatic test_restore_invalid();
        do_reset();
        write = 1'b1; writeregsel = 3'd2; writedata = 16'h1111; step();
        write = 1'b0; ckpt_restore = 1'b1; step();
        idle();
        read1regsel = 3'd2;
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rd1[c] !== 16'h0000 || er[c] !== 1'b1 || cv[c] !== 1'b0) begin
                errors++;
                $display("FAIL restore_empty cfg%0d got r2=%h err=%b valid=%b exp 0000/1/0",
                         c, rd1[c], er[c], cv[c]);
            end
        end
    endtask

    task automatic test_save_restore_same();
        do_reset();
        write = 1'b1; writeregsel = 3'd1; writedata = 16'h0077; ckpt_save = 1'b1; step();
        ckpt_save = 1'b0; writedata = 16'h0099; step();
        write = 1'b0; ckpt_save = 1'b1; ckpt_restore = 1'b1; step();
        idle();
        read1regsel = 3'd1;
        #1;
        checks++;
        if (rd1[CA] !== 16'h0077 || er[CA] !== 1'b1) begin
            errors++;
            $display("FAIL save_restore got r1=%h err=%b exp 0077/1", rd1[CA], er[CA]);
        end
        // The dropped save must not have replaced the checkpoint.
        write = 1'b1; writeregsel = 3'd1; writedata = 16'h0044; step();
        write = 1'b0; ckpt_restore = 1'b1; step();
        idle();
        read1regsel = 3'd1;
        #1;
        checks++;
        if (rd1[CA] !== 16'h0077 || cv[CA] !== 1'b1) begin
            errors++;
            $display("FAIL save_dropped got r1=%h valid=%b exp 0077/1", rd1[CA], cv[CA]);
        end
    endtask

    task automatic test_r0_zero();
        do_reset();
        write = 1'b1; writeregsel = 3'd0; writedata = 16'hABCD; read1regsel = 3'd0;
        #1;
        checks++;
        if (rd1[CD] !== 16'h0000 || rd1[CA] !== 16'hABCD) begin
            errors++;
            $display("FAIL r0_fwd got cfgD=%h cfgA=%h exp 0000/ABCD", rd1[CD], rd1[CA]);
        end
        step();
        write = 1'b0;
        #1;
        checks++;
        if (rd1[CD] !== 16'h0000 || er[CD] !== 1'b0 || rd1[CA] !== 16'hABCD) begin
            errors++;
            $display("FAIL r0_write got cfgD=%h err=%b cfgA=%h exp 0000/0/ABCD",
                     rd1[CD], er[CD], rd1[CA]);
        end
        // Reset landing on a save cycle wins: checkpoint is lost.
        write = 1'b1; writeregsel = 3'd1; writedata = 16'h0005; ckpt_save = 1'b1; step();
        writeregsel = 3'd2; writedata = 16'h0006; rst = 1'b1; step();
        idle();
        read1regsel = 3'd1; read2regsel = 3'd2;
        #1;
        checks++;
        if (cv[CA] !== 1'b0 || rd1[CA] !== 16'h0000 || rd2[CA] !== 16'h0000) begin
            errors++;
            $display("FAIL rst_on_save got valid=%b r1=%h r2=%h exp 0/0000/0000",
                     cv[CA], rd1[CA], rd2[CA]);
        end
        ckpt_restore = 1'b1; step();
        idle();
        read1regsel = 3'd1;
        #1;
        checks++;
        if (er[CA] !== 1'b1 || rd1[CA] !== 16'h0000) begin
            errors++;
            $display("FAIL rst_then_restore got err=%b r1=%h exp 1/0000", er[CA], rd1[CA]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 59) == 0);
            write        = ($urandom_range(0, 1) == 1);
            writeregsel  = 3'($urandom_range(0, 7));
            writedata    = 16'($urandom);
            ckpt_save    = ($urandom_range(0, 7) == 0);
            ckpt_restore = ($urandom_range(0, 9) == 0);
            read1regsel  = 3'($urandom_range(0, 7));
            read2regsel  = ($urandom_range(0, 3) == 0) ? writeregsel : 3'($urandom_range(0, 7));
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (rd1[c] !== exp_read(c, read1regsel)) begin
                    errors++;
                    $display("FAIL rand_rd1 cfg%0d it%0d sel%0d got %h exp %h",
                             c, n, read1regsel, rd1[c], exp_read(c, read1regsel));
                end
                checks++;
                if (rd2[c] !== exp_read(c, read2regsel)) begin
                    errors++;
                    $display("FAIL rand_rd2 cfg%0d it%0d sel%0d got %h exp %h",
                             c, n, read2regsel, rd2[c], exp_read(c, read2regsel));
                end
                checks++;
                if (cv[c] !== m_cv[c] || er[c] !== m_err[c]) begin
                    errors++;
                    $display("FAIL rand_flags cfg%0d it%0d got valid=%b err=%b exp %b/%b",
                             c, n, cv[c], er[c], m_cv[c], m_err[c]);
                end
            end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_ckpt_roundtrip();
        test_bad_index();
        test_restore_invalid();
        test_save_restore_same();
        test_r0_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_param_ckpt.md
Name: rf_param_ckpt

Overview:
- Parametrised successor to the 8x16 two-read/one-write register file.
- Width, register count, write-through bypass and a hardwired-zero R0 are all selectable by parameter.
- Adds a single-level checkpoint: a full shadow copy of the file that can be saved and restored in one cycle. The pipeline uses it to recover architectural state on branch mispredict or exception flush.
- Sits in decode: two read ports feed ID/EX, and the write port is driven from writeback.

Parameters:
DATA_W, 16, width of each register in bits
ADDR_W, 3, width of register select fields
NUM_REGS, 8, number of implemented registers; must be <= 2**ADDR_W
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
R0_ZERO, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
read1regsel  input  ADDR_W  read port 1 select
read2regsel  input  ADDR_W  read port 2 select
writeregsel  input  ADDR_W  write select
writedata  input  DATA_W  write data
write  input  1  write enable
ckpt_save  input  1  copy entire file (including this cycle's write) into shadow
ckpt_restore  input  1  copy shadow into file
read1data  output  DATA_W  read port 1 data
read2data  output  DATA_W  read port 2 data
ckpt_valid  output  1  shadow holds a saved checkpoint
err  output  1  sticky error flag

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at clock edge):
  - all registers and shadow cleared to 0; ckpt_valid=0; err=0.
  - rst has priority over every other input in that cycle.
- Write:
  - on the edge with write=1 and writeregsel<NUM_REGS, reg[writeregsel] <= writedata.
  - writes with writeregsel>=NUM_REGS are dropped and set err.
  - with R0_ZERO=1, writes to index 0 are silently dropped; not an error.
- Read (combinational, zero latency):
  - select >= NUM_REGS returns 0.
  - R0_ZERO=1 and select==0 returns 0.
  - BYPASS=1, write=1, valid writeregsel equal to the select, and no ckpt_restore: return writedata.
  - otherwise return the stored reg[select].
- ckpt_save:
  - on the edge, shadow[i] <= the value reg[i] takes after this cycle's write, for every i.
  - a write in the same cycle is therefore captured in the checkpoint.
  - sets ckpt_valid=1.
- ckpt_restore:
  - on the edge, reg[i] <= shadow[i] for every i.
  - a concurrent write is discarded (restore wins) and is not an error.
  - ckpt_valid is unchanged, so the same checkpoint may be restored repeatedly.
- Restore with ckpt_valid=0: restore proceeds (file goes to the reset/zero shadow) and err is set.
- ckpt_save and ckpt_restore in the same cycle: save ignored, restore performed, err set.
- err:
  - registered; rises on the edge following the offending cycle.
  - held until rst.
- Reset mid-sequence: a rst cycle coinciding with save/restore/write performs only the reset.
- Synthesis constraint: NUM_REGS > 2**ADDR_W is illegal; the implementation must fail elaboration.

Test Plan:
- Reset then read all selects → both ports 0, ckpt_valid=0, err=0. Write R3=0xBEEF, next cycle read1regsel=3 → 0xBEEF; read2regsel=4 → 0x0000.
- BYPASS=1: write=1, writeregsel=5, writedata=0x1234, read1regsel=5 in the same cycle → read1data=0x1234 before the edge. BYPASS=0, same stimulus → old value 0x0000, then 0x1234 after the edge.
- Checkpoint round-trip:
  - R1=0x0011, R2=0x0022; ckpt_save together with write R2=0x00AA → ckpt_valid=1.
  - write R1=0xFFFF, R2=0xEEEE, then ckpt_restore with a concurrent write R1=0x5555.
  - next cycle R1=0x0011, R2=0x00AA, err=0.
- Error paths:
  - NUM_REGS=6, ADDR_W=3: write to index 7 → no register changes, read of index 7 returns 0, err=1 one cycle later and stays 1.
  - separately from reset: ckpt_restore with ckpt_valid=0 → all regs 0, err=1.
  - separately: save+restore in the same cycle → restore only, err=1.
- R0_ZERO=1: write R0=0xABCD → read R0=0x0000, err=0. rst asserted during a ckpt_save cycle → shadow cleared, ckpt_valid=0, and a following restore sets err.
